// File: rtl/regfile_writeback.sv
// Write-side front end for the integer register file: LSU/EXU result arbitration,
// registered write port and RAW busy scoreboard. Optional forward path: REGFILE_WB_FWD_EN.
module regfile_writeback #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic                  exu_valid,
   output logic                  exu_ready,
   input  logic                  exu_wen,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   input  logic [ADDR_WIDTH-1:0] q_raddr1,
   input  logic [ADDR_WIDTH-1:0] q_raddr2,
   output logic                  q_busy1,
   output logic                  q_busy2,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef REGFILE_WB_FWD_EN
   ,
   output logic                  fwd_hit1,
   output logic                  fwd_hit2,
   output logic [DATA_WIDTH-1:0] fwd_data1,
   output logic [DATA_WIDTH-1:0] fwd_data2
`endif
);

   localparam int NREG = 2**ADDR_WIDTH;

   logic                  lsu_fire;
   logic                  exu_fire;
   logic                  wb_fire;
   logic                  fire_wen;
   logic [ADDR_WIDTH-1:0] fire_rd;
   logic [DATA_WIDTH-1:0] fire_data;

   logic [NREG-1:0]       busy_q;
   logic [NREG-1:0]       busy_d;
   logic                  issue_fire;
   logic                  set_en;
   logic                  clr_en;
   logic [ADDR_WIDTH-1:0] clr_idx;

   // Fixed priority: loads never stall, EXU waits whenever a load is presented.
   assign lsu_ready = 1'b1;
   assign exu_ready = !lsu_valid;
   assign lsu_fire  = lsu_valid;
   assign exu_fire  = exu_valid && !lsu_valid;
   assign wb_fire   = lsu_fire || exu_fire;

   always_comb begin
      fire_rd   = exu_rd;
      fire_data = exu_data;
      fire_wen  = exu_fire && exu_wen;
      if (lsu_fire) begin
         fire_rd   = lsu_rd;
         fire_data = lsu_data;
         fire_wen  = 1'b1;
      end
      if (fire_rd == '0) begin
         fire_wen = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= fire_wen;
         if (wb_fire) begin
            rf_waddr <= fire_rd;
            rf_wdata <= fire_data;
         end
      end
   end

   // Issue looks only at registered busy, so a same-cycle clear cannot unblock it.
   assign issue_ready = !busy_q[issue_rd] || (issue_rd == '0);
   assign issue_fire  = issue_valid && issue_ready;
   assign set_en      = issue_fire && (issue_rd != '0);

`ifdef REGFILE_WB_FWD_EN
   assign clr_en  = fire_wen;
   assign clr_idx = fire_rd;
`else
   assign clr_en  = rf_wen;
   assign clr_idx = rf_waddr;
`endif

   // Set is applied after clear so a same-edge conflict leaves the register busy.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_idx] = 1'b0;
      end
      if (set_en) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign q_busy1 = busy_q[q_raddr1] && (q_raddr1 != '0);
   assign q_busy2 = busy_q[q_raddr2] && (q_raddr2 != '0);

`ifdef REGFILE_WB_FWD_EN
   assign fwd_hit1  = rf_wen && (rf_waddr == q_raddr1) && (q_raddr1 != '0);
   assign fwd_hit2  = rf_wen && (rf_waddr == q_raddr2) && (q_raddr2 != '0);
   assign fwd_data1 = rf_wdata;
   assign fwd_data2 = rf_wdata;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback; follows REGFILE_WB_FWD_EN when defined.
module tb_regfile_writeback;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        exu_valid;
   logic        exu_ready;
   logic        exu_wen;
   logic [4:0]  exu_rd;
   logic [31:0] exu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic [4:0]  q_raddr1;
   logic [4:0]  q_raddr2;
   logic        q_busy1;
   logic        q_busy2;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef REGFILE_WB_FWD_EN
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [31:0] fwd_data1;
   logic [31:0] fwd_data2;
`endif

   int checks = 0;
   int errors = 0;

   regfile_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .exu_valid   (exu_valid),
      .exu_ready   (exu_ready),
      .exu_wen     (exu_wen),
      .exu_rd      (exu_rd),
      .exu_data    (exu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .q_raddr1    (q_raddr1),
      .q_raddr2    (q_raddr2),
      .q_busy1     (q_busy1),
      .q_busy2     (q_busy2),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
`ifdef REGFILE_WB_FWD_EN
      ,
      .fwd_hit1    (fwd_hit1),
      .fwd_hit2    (fwd_hit2),
      .fwd_data1   (fwd_data1),
      .fwd_data2   (fwd_data2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      issue_valid = 1'b0; issue_rd = '0;
      exu_valid = 1'b0; exu_wen = 1'b0; exu_rd = '0; exu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      q_raddr1 = '0; q_raddr2 = '0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("init_rf_wen", 32'(rf_wen), 32'd0);
      chk("init_issue_ready", 32'(issue_ready), 32'd1);
      chk("lsu_ready", 32'(lsu_ready), 32'd1);

      // EXU write to x5
      issue_valid = 1'b1; issue_rd = 5'd5;
      #1;
      chk("issue5_ready", 32'(issue_ready), 32'd1);
      step();
      issue_valid = 1'b0;
      q_raddr1 = 5'd5; q_raddr2 = 5'd0;
      exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
      #1;
      chk("x5_busy_N", 32'(q_busy1), 32'd1);
      chk("exu_ready_N", 32'(exu_ready), 32'd1);
      step();
      exu_valid = 1'b0;
      #1;
      chk("exu_rf_wen", 32'(rf_wen), 32'd1);
      chk("exu_rf_waddr", 32'(rf_waddr), 32'd5);
      chk("exu_rf_wdata", rf_wdata, 32'hDEADBEEF);
`ifdef REGFILE_WB_FWD_EN
      chk("x5_busy_N1", 32'(q_busy1), 32'd0);
      chk("x5_fwd_hit", 32'(fwd_hit1), 32'd1);
      chk("x5_fwd_data", fwd_data1, 32'hDEADBEEF);
      chk("x0_fwd_hit2", 32'(fwd_hit2), 32'd0);
`else
      chk("x5_busy_N1", 32'(q_busy1), 32'd1);
`endif
      step();
      chk("x5_busy_N2", 32'(q_busy1), 32'd0);
      chk("idle_rf_wen", 32'(rf_wen), 32'd0);

      // LSU and EXU together: LSU x3 first, EXU x4 one cycle later
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33333333;
      exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd4; exu_data = 32'h44444444;
      #1;
      chk("conf_exu_ready", 32'(exu_ready), 32'd0);
      chk("conf_lsu_ready", 32'(lsu_ready), 32'd1);
      step();
      lsu_valid = 1'b0;
      #1;
      chk("conf_exu_ready_N1", 32'(exu_ready), 32'd1);
      chk("conf_wen_N1", 32'(rf_wen), 32'd1);
      chk("conf_waddr_N1", 32'(rf_waddr), 32'd3);
      chk("conf_wdata_N1", rf_wdata, 32'h33333333);
      step();
      exu_valid = 1'b0;
      chk("conf_wen_N2", 32'(rf_wen), 32'd1);
      chk("conf_waddr_N2", 32'(rf_waddr), 32'd4);
      chk("conf_wdata_N2", rf_wdata, 32'h44444444);

      // x0 target and exu_wen=0
      exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd0; exu_data = 32'h00001234;
      q_raddr1 = 5'd0;
      #1;
      chk("x0_exu_ready", 32'(exu_ready), 32'd1);
      chk("x0_q_busy", 32'(q_busy1), 32'd0);
      step();
      exu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd7;
      chk("x0_rf_wen", 32'(rf_wen), 32'd0);
      step();
      issue_valid = 1'b0;
      exu_valid = 1'b1; exu_wen = 1'b0; exu_rd = 5'd7; exu_data = 32'h77777777;
      q_raddr2 = 5'd7;
      #1;
      chk("nowen_busy_before", 32'(q_busy2), 32'd1);
      step();
      exu_valid = 1'b0;
      chk("nowen_rf_wen", 32'(rf_wen), 32'd0);
      step();
      chk("nowen_busy_after", 32'(q_busy2), 32'd1);

      // Hazard stall on x9
      issue_valid = 1'b1; issue_rd = 5'd9; q_raddr1 = 5'd9;
      #1;
      chk("x9_first_ready", 32'(issue_ready), 32'd1);
      step();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99999999;
      chk("x9_stall_M", 32'(issue_ready), 32'd0);
      step();
      lsu_valid = 1'b0;
      chk("x9_wen_M1", 32'(rf_wen), 32'd1);
`ifdef REGFILE_WB_FWD_EN
      chk("x9_ready_M1", 32'(issue_ready), 32'd1);
`else
      chk("x9_stall_M1", 32'(issue_ready), 32'd0);
      step();
      chk("x9_ready_M2", 32'(issue_ready), 32'd1);
`endif
      step();
      issue_valid = 1'b0;
      chk("x9_reissued_busy", 32'(q_busy1), 32'd1);

      // Same-edge clear and set of x9: set wins
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h90000001;
      step();
      lsu_data = 32'h90000002;
`ifdef REGFILE_WB_FWD_EN
      issue_valid = 1'b1; issue_rd = 5'd9;
      #1;
      chk("setwin_ready", 32'(issue_ready), 32'd1);
      step();
      lsu_valid = 1'b0; issue_valid = 1'b0;
`else
      step();
      lsu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      #1;
      chk("setwin_ready", 32'(issue_ready), 32'd1);
      chk("setwin_clr_wen", 32'(rf_wen), 32'd1);
`endif
      step();
      issue_valid = 1'b0;
      chk("setwin_busy", 32'(q_busy1), 32'd1);

      // Back-to-back LSU writes x1..x4
      for (int i = 1; i <= 4; i++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = 32'h11111111 * 32'(i);
         step();
         chk("b2b_wen", 32'(rf_wen), 32'd1);
         chk("b2b_waddr", 32'(rf_waddr), 32'(i));
         chk("b2b_wdata", rf_wdata, 32'h11111111 * 32'(i));
      end
      lsu_valid = 1'b0;
      step();
      chk("b2b_tail_wen", 32'(rf_wen), 32'd0);

      // Reset mid-traffic
      lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66666666;
      issue_valid = 1'b1; issue_rd = 5'd10;
      rst = 1'b1;
      step(); step();
      rst = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
      #1;
      chk("rst_rf_wen", 32'(rf_wen), 32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      issue_rd = 5'd9;
      #1;
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);
      for (int a = 0; a < 32; a++) begin
         q_raddr1 = 5'(a);
         #1;
         chk("rst_busy", 32'(q_busy1), 32'd0);
      end
      step();
      chk("rst_rf_wen_after", 32'(rf_wen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end for the integer register file.
- Accepts results from EXU and LSU through valid/ready handshakes and arbitrates between them.
- Drives one registered write port (rf_wen/rf_waddr/rf_wdata) into the register file.
- Keeps a per-register busy scoreboard, set at issue and cleared at writeback, so IDU can stall on RAW hazards.

Parameters:
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- issue_valid  input  1  IDU issues an instruction that will write issue_rd
- issue_rd  input  ADDR_WIDTH  destination register of the issuing instruction
- issue_ready  output  1  issue accepted this cycle
- exu_valid  input  1  EXU result valid
- exu_ready  output  1  EXU result accepted
- exu_wen  input  1  EXU result writes a register
- exu_rd  input  ADDR_WIDTH  EXU destination register
- exu_data  input  DATA_WIDTH  EXU result data
- lsu_valid  input  1  load data valid
- lsu_ready  output  1  load data accepted
- lsu_rd  input  ADDR_WIDTH  load destination register
- lsu_data  input  DATA_WIDTH  load data
- q_raddr1  input  ADDR_WIDTH  hazard query address 1
- q_raddr2  input  ADDR_WIDTH  hazard query address 2
- q_busy1  output  1  q_raddr1 has a pending write
- q_busy2  output  1  q_raddr2 has a pending write
- rf_wen  output  1  register file write enable
- rf_waddr  output  ADDR_WIDTH  register file write address
- rf_wdata  output  DATA_WIDTH  register file write data

Behaviour:
- Reset values:
  - rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits=0.
  - Any accepted-but-unwritten result is discarded; rf_wen is 0 in the cycle after rst.
- Arbitration (fixed priority, LSU over EXU):
  - lsu_ready=1 always.
  - exu_ready=!lsu_valid.
  - Fire: lsu_fire=lsu_valid; exu_fire=exu_valid&&!lsu_valid.
- Output register (latency 1):
  - A fire in cycle N loads rf_waddr/rf_wdata at the edge ending N.
  - rf_wen=1 in N+1 iff the fire writes: LSU always writes; EXU writes iff exu_wen.
  - The register file commits at the edge ending N+1.
  - With no fire, rf_wen=0 in N+1 and rf_waddr/rf_wdata hold their values.
- x0: a fire with rd==0 is accepted (ready per arbitration), gives rf_wen=0, and never touches busy.
- EXU fire with exu_wen=0: handshake completes, no write, busy unchanged.
- Scoreboard, busy[i] (1 bit per register):
  - issue_ready=!busy[issue_rd] || issue_rd==0, from registered busy only.
  - An issue is blocked while busy even if that register clears in the same cycle.
  - Issue fire with issue_rd!=0 sets busy[issue_rd] at the edge.
  - Clear: when rf_wen=1, busy[rf_waddr] clears at the edge ending that cycle, so it is visible 2 cycles after the fire.
  - Simultaneous set and clear of the same index: set wins.
  - A write to a non-busy register is legal and leaves busy unchanged.
- Queries:
  - q_busyK=busy[q_raddrK] combinationally.
  - q_busyK is forced to 0 when q_raddrK==0.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- When defined:
  - Adds outputs fwd_hit1/fwd_hit2 (1) and fwd_data1/fwd_data2 (DATA_WIDTH).
  - fwd_hitK=rf_wen&&rf_waddr==q_raddrK&&q_raddrK!=0; fwd_dataK=rf_wdata.
  - busy clears at the fire edge (visible N+1) instead of at rf_wen; the consumer takes data from the forward path.
  - Set still wins on same-edge conflict.
- When undefined: no forward ports; clear timing as specified above.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic -> next cycle rf_wen=0, rf_waddr=0, q_busy1=0 for all addresses, issue_ready=1.
- EXU write: issue rd=5; EXU fire rd=5, data=0xDEADBEEF in cycle N -> rf_wen=1, waddr=5, wdata=0xDEADBEEF in N+1; q_busy(5)=1 through N+1, 0 in N+2 (N+1 with REGFILE_WB_FWD_EN, with fwd_hit=1, fwd_data=0xDEADBEEF).
- Conflict: lsu_valid and exu_valid together, rd 3 and 4 -> exu_ready=0, rf writes x3 (LSU data) in N+1; EXU accepted in N+1, writes x4 in N+2.
- x0 and no-write: EXU fire rd=0, data=0x1234 -> rf_wen=0. EXU fire rd=7, exu_wen=0 -> rf_wen=0 and busy[7] unchanged.
- Hazard stall: issue rd=9 accepted; second issue rd=9 -> issue_ready=0 until the cycle after busy[9] clears. Issue rd=9 in the same cycle as the x9 clear -> busy[9] stays 1.
- Back-to-back: LSU fires 4 consecutive cycles, rd 1,2,3,4 -> rf_wen=1 for 4 consecutive cycles, in order, with no bubbles.
